// File: rtl/cpu_boot_sequencer_pkg.sv
// Shared constants and types for the CPU boot sequencer and the 3-bit CPU it feeds.
package cpu_boot_sequencer_pkg;

    localparam int DATA_W      = 9;
    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int RUN_W       = 8;
    localparam int LEN_W       = 4;
    localparam int CRST_CYCLES = 2;
    localparam int CRST_CNT_W  = $clog2(CRST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LOAD,
        FILL,
        RUN,
        DONE
    } boot_state_e;

    // Requested program lengths beyond the RAM depth load the whole RAM.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] prog_len);
        return (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    endfunction

endpackage

// File: rtl/cpu_boot_sequencer_if.sv
// Instruction stream from the host/loader into the boot sequencer.
interface cpu_boot_sequencer_if;
    import cpu_boot_sequencer_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/boot_run_counter.sv
// Loadable down-counter for the PC_Enable budget; a loaded value of 0 never expires.
module boot_run_counter
    import cpu_boot_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RUN_W-1:0] load_value,
    input  logic             dec,
    output logic             expire
);

    logic [RUN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == RUN_W'(1));

endmodule

// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer: pulses CPU reset, streams the program into RAM, zero-fills the
// remaining words, then enables the PC for a programmed number of cycles.
module cpu_boot_sequencer
    import cpu_boot_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [LEN_W-1:0]    prog_len,
    input  logic [RUN_W-1:0]    run_cycles,
    cpu_boot_sequencer_if.slave stream,
    output logic                cpu_reset,
    output logic [DATA_W-1:0]   RAM_Write_Data,
    output logic [ADDR_W-1:0]   RAM_Write_Address,
    output logic                RAM_Write_Enable,
    output logic                PC_Enable,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    boot_state_e           state, next_state;
    logic [LEN_W-1:0]      len;
    logic [ADDR_W-1:0]     addr;
    logic [CRST_CNT_W-1:0] crst_cnt;
    logic                  start_hit, abort_hit, addr_inc, run_expire;
    logic                  wr_en_d;
    logic [DATA_W-1:0]     wr_data_d;
    logic [ADDR_W-1:0]     wr_addr_d;

    assign stream.in_ready = (state == LOAD);

    boot_run_counter u_run_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (start_hit),
        .load_value (run_cycles),
        .dec        (state == RUN),
        .expire     (run_expire)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        next_state = state;
        start_hit  = 1'b0;
        abort_hit  = 1'b0;
        addr_inc   = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = '0;
        wr_addr_d  = '0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = CRST;
                    start_hit  = 1'b1;
                end
            end
            CRST: begin
                if (crst_cnt == CRST_CNT_W'(CRST_CYCLES - 1)) begin
                    next_state = (len == '0) ? FILL : LOAD;
                end
            end
            LOAD: begin
                if (stream.in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = stream.in_data;
                    wr_addr_d = addr;
                    addr_inc  = 1'b1;
                    if (LEN_W'(addr) == len - LEN_W'(1)) begin
                        next_state = (len < LEN_W'(DEPTH)) ? FILL : RUN;
                    end
                end
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr;
                addr_inc  = 1'b1;
                if (addr == ADDR_W'(DEPTH - 1)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (run_expire) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = CRST;
                    start_hit  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase

        // Abort wins over everything, including a write being registered this edge.
        if (abort && (state inside {CRST, LOAD, FILL, RUN})) begin
            next_state = DONE;
            abort_hit  = 1'b1;
            wr_en_d    = 1'b0;
            wr_data_d  = '0;
            wr_addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            len               <= '0;
            addr              <= '0;
            crst_cnt          <= '0;
            cpu_reset         <= 1'b0;
            RAM_Write_Data    <= '0;
            RAM_Write_Address <= '0;
            RAM_Write_Enable  <= 1'b0;
            PC_Enable         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= next_state;
            if (start_hit) begin
                len  <= clamp_len(prog_len);
                addr <= '0;
            end else if (addr_inc) begin
                addr <= addr + 1'b1;
            end
            crst_cnt <= (state == CRST && next_state == CRST) ? crst_cnt + 1'b1 : '0;

            cpu_reset         <= (next_state == CRST);
            RAM_Write_Enable  <= wr_en_d;
            RAM_Write_Data    <= wr_data_d;
            RAM_Write_Address <= wr_addr_d;
            PC_Enable         <= (next_state == RUN);
            busy              <= !(next_state inside {IDLE, DONE});
            done              <= (next_state == DONE);
            aborted           <= (next_state == DONE) && (abort_hit || (state == DONE && aborted));
        end
    end

endmodule
